dq_pi_controller: RTL and testbench

Dual-channel PI current regulator placed directly downstream of the park transform. It consumes the d/q measurements, regulates each against a reference, and produces the d/q voltage commands that feed antiPark. One registered multiplier is time-shared across the d and q channels under a small FSM. Integrators are clamped to the output limits for anti-windup.

---
 rtl/dq_pi_pkg.sv | 44 ++++
 rtl/dq_pi_controller_saturator.sv | 36 +++
 rtl/dq_pi_controller.sv | 199 +++++++++++++++++++
 tb/tb_dq_pi_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dq_pi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dq_pi_pkg
// Description : Shared types and width helpers for the d/q PI regulator.
// Revision    : 1.0 - initial release
// ============================================================================
package dq_pi_pkg;

  // Sequencer states: d channel first, then q channel, one multiply per state
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_P   = 3'd1,
    D_I   = 3'd2,
    D_UPD = 3'd3,
    Q_P   = 3'd4,
    Q_I   = 3'd5,
    Q_UPD = 3'd6
  } state_t;

  // Default datapath sizes
  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_GAIN_WIDTH = 18;

  // Error difference needs one extra bit before saturation
  function automatic int err_width(input int data_width);
    return data_width + 1;
  endfunction

  // Full-precision product of gain and error
  function automatic int prod_width(input int data_width, input int gain_width);
    return data_width + gain_width;
  endfunction

  // Accumulation width: product width plus two guard bits
  function automatic int sum_width(input int data_width, input int gain_width);
    return data_width + gain_width + 2;
  endfunction

  localparam int ERR_WIDTH  = err_width(DEF_DATA_WIDTH);
  localparam int PROD_WIDTH = prod_width(DEF_DATA_WIDTH, DEF_GAIN_WIDTH);
  localparam int SUM_WIDTH  = sum_width(DEF_DATA_WIDTH, DEF_GAIN_WIDTH);

endpackage
`default_nettype wire

// File: rtl/dq_pi_controller_saturator.sv
`default_nettype none
// ============================================================================
// Module      : signed_saturator
// Description : Combinational signed clamp of a wide value into [lo, hi].
//               The upper bound is applied first, then the lower bound, so an
//               inverted range (lo > hi) always yields lo.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_saturator #(
  parameter int IN_WIDTH  = 19,
  parameter int OUT_WIDTH = 18
) (
  input  logic [IN_WIDTH-1:0]  in_val,
  input  logic [OUT_WIDTH-1:0] lo,
  input  logic [OUT_WIDTH-1:0] hi,
  output logic [OUT_WIDTH-1:0] out_val
);

  logic signed [IN_WIDTH-1:0] w_in;
  logic signed [IN_WIDTH-1:0] w_lo;
  logic signed [IN_WIDTH-1:0] w_hi;
  logic                       w_gt;
  logic                       w_lt;

  assign w_in = in_val;
  assign w_lo = {{(IN_WIDTH-OUT_WIDTH){lo[OUT_WIDTH-1]}}, lo};
  assign w_hi = {{(IN_WIDTH-OUT_WIDTH){hi[OUT_WIDTH-1]}}, hi};

  // Upper clamp first; the lower test then sees either hi or the raw input
  assign w_gt = (w_in > w_hi);
  assign w_lt = w_gt ? ($signed(hi) < $signed(lo)) : (w_in < w_lo);

  assign out_val = w_lt ? lo : (w_gt ? hi : in_val[OUT_WIDTH-1:0]);

endmodule
`default_nettype wire

// File: rtl/dq_pi_controller.sv
`default_nettype none
// ============================================================================
// Module      : dq_pi_controller
// Description : Dual-channel (d/q) PI current regulator. A single registered
//               multiplier is time-shared across both channels by a 7-state
//               sequencer; integrators are clamped to the output limits.
// Revision    : 1.0 - initial release
// ============================================================================
module dq_pi_controller
  import dq_pi_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int GAIN_WIDTH = 18,
  parameter int GAIN_FRAC  = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic [DATA_WIDTH-1:0] d_ref,
  input  logic [DATA_WIDTH-1:0] q_ref,
  input  logic [GAIN_WIDTH-1:0] kp,
  input  logic [GAIN_WIDTH-1:0] ki,
  input  logic [DATA_WIDTH-1:0] limit_max,
  input  logic [DATA_WIDTH-1:0] limit_min,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int c_err_w  = err_width(DATA_WIDTH);
  localparam int c_prod_w = prod_width(DATA_WIDTH, GAIN_WIDTH);
  localparam int c_sum_w  = sum_width(DATA_WIDTH, GAIN_WIDTH);

  localparam logic [DATA_WIDTH-1:0] c_data_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_data_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                        r_state;
  logic signed [DATA_WIDTH-1:0]  r_e_d;
  logic signed [DATA_WIDTH-1:0]  r_e_q;
  logic signed [GAIN_WIDTH-1:0]  r_kp;
  logic signed [GAIN_WIDTH-1:0]  r_ki;
  logic        [DATA_WIDTH-1:0]  r_lmax;
  logic        [DATA_WIDTH-1:0]  r_lmin;
  logic signed [c_prod_w-1:0]    r_prod;
  logic signed [c_prod_w-1:0]    r_p;
  logic signed [DATA_WIDTH-1:0]  r_int_d;
  logic signed [DATA_WIDTH-1:0]  r_int_q;
  logic        [DATA_WIDTH-1:0]  r_u_d;

  logic        [c_err_w-1:0]     w_diff_d;
  logic        [c_err_w-1:0]     w_diff_q;
  logic        [DATA_WIDTH-1:0]  w_e_d;
  logic        [DATA_WIDTH-1:0]  w_e_q;
  logic signed [GAIN_WIDTH-1:0]  w_gain;
  logic signed [DATA_WIDTH-1:0]  w_err;
  logic signed [c_prod_w-1:0]    w_mult;
  logic signed [c_prod_w-1:0]    w_shift;
  logic signed [DATA_WIDTH-1:0]  w_int_cur;
  logic signed [c_sum_w-1:0]     w_int_sum;
  logic signed [DATA_WIDTH-1:0]  w_int_new;
  logic signed [c_sum_w-1:0]     w_u_sum;
  logic        [DATA_WIDTH-1:0]  w_u_new;

  // Errors are formed one bit wider, then saturated to the data range
  assign w_diff_d = {d_ref[DATA_WIDTH-1], d_ref} - {d_in[DATA_WIDTH-1], d_in};
  assign w_diff_q = {q_ref[DATA_WIDTH-1], q_ref} - {q_in[DATA_WIDTH-1], q_in};

  signed_saturator #(.IN_WIDTH(c_err_w), .OUT_WIDTH(DATA_WIDTH)) u_sat_ed (
    .in_val (w_diff_d),
    .lo     (c_data_min),
    .hi     (c_data_max),
    .out_val(w_e_d)
  );

  signed_saturator #(.IN_WIDTH(c_err_w), .OUT_WIDTH(DATA_WIDTH)) u_sat_eq (
    .in_val (w_diff_q),
    .lo     (c_data_min),
    .hi     (c_data_max),
    .out_val(w_e_q)
  );

  // Shared multiplier operand selection: kp in *_P states, ki otherwise
  assign w_gain = (r_state == D_P || r_state == Q_P) ? r_kp : r_ki;
  assign w_err  = (r_state == D_P || r_state == D_I) ? r_e_d : r_e_q;
  assign w_mult = c_prod_w'(w_gain) * c_prod_w'(w_err);

  // Arithmetic shift gives floor rounding of the fixed-point product
  assign w_shift = r_prod >>> GAIN_FRAC;

  // Integrator update and output sum; one clamp pair serves both channels
  assign w_int_cur = (r_state == Q_UPD) ? r_int_q : r_int_d;
  assign w_int_sum = c_sum_w'(w_int_cur) + c_sum_w'(w_shift);

  signed_saturator #(.IN_WIDTH(c_sum_w), .OUT_WIDTH(DATA_WIDTH)) u_sat_int (
    .in_val (w_int_sum),
    .lo     (r_lmin),
    .hi     (r_lmax),
    .out_val(w_int_new)
  );

  assign w_u_sum = c_sum_w'(r_p) + c_sum_w'(w_int_new);

  signed_saturator #(.IN_WIDTH(c_sum_w), .OUT_WIDTH(DATA_WIDTH)) u_sat_out (
    .in_val (w_u_sum),
    .lo     (r_lmin),
    .hi     (r_lmax),
    .out_val(w_u_new)
  );

  // Sequencer: captures a sample, runs P/I/update for d then q, strobes result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_e_d     <= '0;
      r_e_q     <= '0;
      r_kp      <= '0;
      r_ki      <= '0;
      r_lmax    <= '0;
      r_lmin    <= '0;
      r_prod    <= '0;
      r_p       <= '0;
      r_int_d   <= '0;
      r_int_q   <= '0;
      r_u_d     <= '0;
      d_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (!enable) begin
      r_state   <= IDLE;
      r_prod    <= '0;
      r_p       <= '0;
      r_int_d   <= '0;
      r_int_q   <= '0;
      r_u_d     <= '0;
      d_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_e_d   <= w_e_d;
            r_e_q   <= w_e_q;
            r_kp    <= kp;
            r_ki    <= ki;
            r_lmax  <= limit_max;
            r_lmin  <= limit_min;
            busy    <= 1'b1;
            r_state <= D_P;
          end
        end
        D_P: begin
          r_prod  <= w_mult;
          r_state <= D_I;
        end
        D_I: begin
          r_p     <= w_shift;
          r_prod  <= w_mult;
          r_state <= D_UPD;
        end
        D_UPD: begin
          r_int_d <= w_int_new;
          r_u_d   <= w_u_new;
          r_state <= Q_P;
        end
        Q_P: begin
          r_prod  <= w_mult;
          r_state <= Q_I;
        end
        Q_I: begin
          r_p     <= w_shift;
          r_prod  <= w_mult;
          r_state <= Q_UPD;
        end
        Q_UPD: begin
          r_int_q   <= w_int_new;
          d_out     <= r_u_d;
          q_out     <= w_u_new;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dq_pi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dq_pi_controller
// Description : Self-checking bench for dq_pi_controller with a behavioural
//               reference model of the PI law.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dq_pi_controller;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [17:0] d_in, q_in, d_ref, q_ref;
  logic [17:0] kp, ki, limit_max, limit_min;
  logic [17:0] d_out, q_out;
  logic        out_valid;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  longint m_int_d = 0;
  longint m_int_q = 0;

  dq_pi_controller #(.DATA_WIDTH(18), .GAIN_WIDTH(18), .GAIN_FRAC(12)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .d_in     (d_in),
    .q_in     (q_in),
    .d_ref    (d_ref),
    .q_ref    (q_ref),
    .kp       (kp),
    .ki       (ki),
    .limit_max(limit_max),
    .limit_min(limit_min),
    .d_out    (d_out),
    .q_out    (q_out),
    .out_valid(out_valid),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [17:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clampf(input longint x, input longint lo, input longint hi);
    longint t;
    t = (x > hi) ? hi : x;
    return (t < lo) ? lo : t;
  endfunction

  // Floor division by 2^12 written as plain integer arithmetic
  function automatic longint fdiv(input longint a);
    longint q;
    q = a / 4096;
    if ((a % 4096) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint pi_chan(input longint e, input longint g_p, input longint g_i,
                                     input longint lo, input longint hi, inout longint integ);
    integ = clampf(integ + fdiv(g_i * e), lo, hi);
    return clampf(fdiv(g_p * e) + integ, lo, hi);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input longint dr, input longint di, input longint qr, input longint qi);
    d_ref = 18'(dr);
    d_in  = 18'(di);
    q_ref = 18'(qr);
    q_in  = 18'(qi);
  endtask

  task automatic set_gain(input longint p, input longint i, input longint hi, input longint lo);
    kp        = 18'(p);
    ki        = 18'(i);
    limit_max = 18'(hi);
    limit_min = 18'(lo);
  endtask

  task automatic randomize_inputs();
    d_ref = 18'($urandom); d_in = 18'($urandom);
    q_ref = 18'($urandom); q_in = 18'($urandom);
    kp = 18'($urandom); ki = 18'($urandom);
    limit_max = 18'($urandom); limit_min = 18'($urandom);
  endtask

  // Issue one sample now, predict it, and watch for exactly one strobe at +6
  task automatic sample(input string tag, input bit scramble);
    longint ed, eq, xd, xq;
    int cnt, pos;
    logic [17:0] od, oq;
    ed = clampf(sx(d_ref) - sx(d_in), -131072, 131071);
    eq = clampf(sx(q_ref) - sx(q_in), -131072, 131071);
    xd = pi_chan(ed, sx(kp), sx(ki), sx(limit_min), sx(limit_max), m_int_d);
    xq = pi_chan(eq, sx(kp), sx(ki), sx(limit_min), sx(limit_max), m_int_q);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, longint'(busy), 1);
    if (scramble) randomize_inputs();
    cnt = 0; pos = 0; od = '0; oq = '0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (out_valid) begin
        cnt++; pos = c; od = d_out; oq = q_out;
      end
    end
    check({tag, "_vcnt"}, cnt, 1);
    check({tag, "_vpos"}, pos, 6);
    check({tag, "_d"}, sx(od), xd);
    check({tag, "_q"}, sx(oq), xq);
  endtask

  initial begin
    int cnt, pos, bcnt;
    longint xd, xq, ed, eq;
    logic [17:0] od, oq;
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0;
    set_in(0, 0, 0, 0);
    set_gain(0, 0, 0, 0);
    tick(); tick();
    check("rst_d", sx(d_out), 0);
    check("rst_q", sx(q_out), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    #2 reset = 1'b1;
    tick();
    enable = 1'b1;
    tick();

    // Scenario 1: basic PI step and latency, repeated for integrator growth
    set_gain('h1000, 'h0400, 2000, -2000);
    set_in(1000, 0, 0, 200);
    sample("s1a", 0);
    sample("s1b", 0);

    // Scenario 2: anti-windup and recovery
    set_in(10000, 0, 0, 0);
    sample("aw1", 0);
    check("aw1_int", sx(dut.r_int_d), m_int_d);
    set_in(0, 0, 0, 0);
    sample("aw2", 0);
    set_in(-400, 0, 0, 0);
    sample("aw3", 0);
    check("aw3_int", sx(dut.r_int_d), m_int_d);

    // Scenario 3: error saturation at full scale
    set_gain('h1000, 0, 131071, -131072);
    set_in(131071, -131072, -131072, 131071);
    sample("esat", 0);
    check("esat_ed", sx(dut.r_e_d), 131071);
    check("esat_eq", sx(dut.r_e_q), -131072);

    // Scenario 4: in_valid while busy is dropped
    set_gain('h1000, 'h0400, 2000, -2000);
    set_in(300, 100, -50, 50);
    ed = clampf(sx(d_ref) - sx(d_in), -131072, 131071);
    eq = clampf(sx(q_ref) - sx(q_in), -131072, 131071);
    xd = pi_chan(ed, sx(kp), sx(ki), sx(limit_min), sx(limit_max), m_int_d);
    xq = pi_chan(eq, sx(kp), sx(ki), sx(limit_min), sx(limit_max), m_int_q);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0; pos = 0; bcnt = busy ? 1 : 0; od = '0; oq = '0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) begin
        set_in(-1500, 700, 1800, -900);
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      if (c <= 5 && busy) bcnt++;
      if (out_valid) begin
        cnt++; pos = c; od = d_out; oq = q_out;
      end
    end
    check("drop_busycnt", bcnt, 6);
    check("drop_busylow", longint'(busy), 0);
    check("drop_vcnt", cnt, 1);
    check("drop_vpos", pos, 6);
    check("drop_d", sx(od), xd);
    check("drop_q", sx(oq), xq);
    set_in(-200, 0, 400, 0);
    sample("drop_next", 0);

    // Scenario 5: enable falls mid-computation
    set_gain('h1000, 'h0400, 2000, -2000);
    set_in(1000, 0, 0, 200);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    enable = 1'b0;
    cnt = 0;
    for (int c = 3; c <= 9; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("en_vcnt", cnt, 0);
    check("en_d", sx(d_out), 0);
    check("en_q", sx(q_out), 0);
    check("en_intd", sx(dut.r_int_d), 0);
    check("en_intq", sx(dut.r_int_q), 0);
    check("en_busy", longint'(busy), 0);
    m_int_d = 0; m_int_q = 0;
    enable = 1'b1;
    tick();
    sample("en_re", 0);
    check("en_re_abs", sx(d_out), 1250);

    // Scenario 6: asynchronous reset between clock edges
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("ar_d", sx(d_out), 0);
    check("ar_q", sx(q_out), 0);
    check("ar_busy", longint'(busy), 0);
    check("ar_int", sx(dut.r_int_d), 0);
    tick(); tick();
    #3 reset = 1'b1;
    m_int_d = 0; m_int_q = 0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("ar_vcnt", cnt, 0);

    // Randomized samples, inputs scrambled while each sample is in flight
    for (int n = 0; n < 40; n++) begin
      randomize_inputs();
      if (n % 3 == 0) begin
        kp = 18'($urandom_range(0, 'h3000));
        ki = 18'($urandom_range(0, 'h1000));
        limit_max = 18'($urandom_range(0, 60000));
        limit_min = 18'(-longint'($urandom_range(0, 60000)));
      end
      sample("rnd", 1'b1);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
